// File: rtl/exec_report_receiver.sv
// Exchange execution-report receiver: frame check, sequence tracking and a FWFT report FIFO.
// Optional checksum verification is compiled in with the EXEC_RX_CHECKSUM_EN macro.
module exec_report_receiver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] rx_data,
  input  logic         rx_valid,
  output logic         rpt_valid,
  input  logic         rpt_ready,
  output logic [7:0]   rpt_type,
  output logic [31:0]  rpt_order_id,
  output logic [31:0]  rpt_price,
  output logic [23:0]  rpt_qty,
  output logic         seq_gap,
  output logic         bad_frame,
  output logic         synced,
  output logic [15:0]  drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 96;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef EXEC_RX_CHECKSUM_EN
  localparam int CHK_LSB = 0;
`else
  localparam int CHK_LSB = 8;
`endif

  typedef enum logic {
    UNSYNC = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef EXEC_RX_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [119:0] b);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 15; i++) begin
      acc = acc ^ b[i*8 +: 8];
    end
    return acc;
  endfunction
`endif

  // Stage p0: check stage holding the sampled frame
  logic                 vld_p0_q, vld_p0_d;
  logic [127:CHK_LSB]   data_p0_q, data_p0_d;

  state_t               state_q, state_d;
  logic [15:0]          exp_seq_q, exp_seq_d;
  logic                 seq_gap_q, seq_gap_d;
  logic                 bad_frame_q, bad_frame_d;
  logic [15:0]          drop_q, drop_d;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  logic [7:0]           f_magic;
  logic [7:0]           f_type;
  logic [15:0]          f_seq;
  logic [31:0]          f_oid;
  logic [31:0]          f_price;
  logic [23:0]          f_qty;
  logic                 csum_ok;
  logic                 frame_good;
  logic                 wr_en;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [EW-1:0]        wr_entry;
  logic [EW-1:0]        head;

  assign f_magic = data_p0_q[127:120];
  assign f_type  = data_p0_q[119:112];
  assign f_seq   = data_p0_q[111:96];
  assign f_oid   = data_p0_q[95:64];
  assign f_price = data_p0_q[63:32];
  assign f_qty   = data_p0_q[31:8];

`ifdef EXEC_RX_CHECKSUM_EN
  assign csum_ok = (data_p0_q[7:0] == xor_bytes(data_p0_q[127:8]));
`else
  assign csum_ok = 1'b1;
`endif

  assign frame_good = (f_magic == 8'hA5) && csum_ok &&
                      ((f_type == 8'h01) || (f_type == 8'h02) || (f_type == 8'h03));

  assign wr_en    = vld_p0_q && frame_good;
  assign full     = (count_q == DEPTH_C);
  assign pop      = rpt_valid && rpt_ready;
  // A pop on the same edge frees the slot, so a full FIFO still takes the write.
  assign push     = wr_en && (!full || pop);
  assign drop     = wr_en && full && !pop;
  assign wr_entry = {f_type, f_oid, f_price, f_qty};

  always_comb begin
    vld_p0_d    = rx_valid;
    data_p0_d   = rx_data[127:CHK_LSB];
    state_d     = state_q;
    exp_seq_d   = exp_seq_q;
    seq_gap_d   = 1'b0;
    bad_frame_d = 1'b0;
    drop_d      = drop ? sat_inc16(drop_q) : drop_q;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Stage p1: sequence tracking; dropped frames still advance the sequence
    if (vld_p0_q) begin
      if (!frame_good) begin
        bad_frame_d = 1'b1;
      end else begin
        exp_seq_d = f_seq + 16'd1;
        state_d   = LOCKED;
        if ((state_q == LOCKED) && (f_seq != exp_seq_q)) begin
          seq_gap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q    <= 1'b0;
      data_p0_q   <= '0;
      state_q     <= UNSYNC;
      exp_seq_q   <= 16'h0000;
      seq_gap_q   <= 1'b0;
      bad_frame_q <= 1'b0;
      drop_q      <= 16'h0000;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      data_p0_q   <= data_p0_d;
      state_q     <= state_d;
      exp_seq_q   <= exp_seq_d;
      seq_gap_q   <= seq_gap_d;
      bad_frame_q <= bad_frame_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Fields are forced to zero whenever the buffer is empty, which also covers reset.
  assign head         = mem_q[rd_ptr_q];
  assign rpt_valid    = (count_q != '0);
  assign rpt_type     = rpt_valid ? head[95:88] : 8'h00;
  assign rpt_order_id = rpt_valid ? head[87:56] : 32'h0;
  assign rpt_price    = rpt_valid ? head[55:24] : 32'h0;
  assign rpt_qty      = rpt_valid ? head[23:0]  : 24'h0;
  assign seq_gap      = seq_gap_q;
  assign bad_frame    = bad_frame_q;
  assign synced       = (state_q == LOCKED);
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_exec_report_receiver.sv
// Directed testbench for exec_report_receiver with hand-computed expectations.
module tb_exec_report_receiver;

  logic         clk;
  logic         reset;
  logic [127:0] rx_data;
  logic         rx_valid;
  logic         rpt_valid;
  logic         rpt_ready;
  logic [7:0]   rpt_type;
  logic [31:0]  rpt_order_id;
  logic [31:0]  rpt_price;
  logic [23:0]  rpt_qty;
  logic         seq_gap;
  logic         bad_frame;
  logic         synced;
  logic [15:0]  drop_count;

  int checks;
  int failures;

  exec_report_receiver #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_type     (rpt_type),
    .rpt_order_id (rpt_order_id),
    .rpt_price    (rpt_price),
    .rpt_qty      (rpt_qty),
    .seq_gap      (seq_gap),
    .bad_frame    (bad_frame),
    .synced       (synced),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [7:0] m, input logic [7:0] t,
                                      input logic [15:0] s, input logic [31:0] o,
                                      input logic [31:0] p, input logic [23:0] q);
    logic [127:0] f;
    logic [7:0]   c;
    f = {m, t, s, o, p, q, 8'h00};
    c = 8'h00;
    for (int i = 1; i < 16; i++) c = c ^ f[i*8 +: 8];
    f[7:0] = c;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] f);
    rx_data  = f;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [127:0] f;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    rx_data   = '0;
    rx_valid  = 1'b0;
    rpt_ready = 1'b0;
    tick();
    tick();
    chk("rst_rpt_valid", rpt_valid, 0);
    chk("rst_synced", synced, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_gap", seq_gap, 0);
    chk("rst_bad", bad_frame, 0);
    chk("rst_type", rpt_type, 0);
    reset = 1'b0;
    tick();
    chk("unsync_after_rst", synced, 0);

    // First FILL: report appears right after the edge following sampling
    send(mk(8'hA5, 8'h02, 16'h0010, 32'h11223344, 32'h00000BB8, 24'h000064));
    chk("fill_not_yet", rpt_valid, 0);
    tick();
    chk("fill_valid", rpt_valid, 1);
    chk("fill_synced", synced, 1);
    chk("fill_gap", seq_gap, 0);
    chk("fill_type", rpt_type, 8'h02);
    chk("fill_oid", rpt_order_id, 32'h11223344);
    chk("fill_price", rpt_price, 32'h00000BB8);
    chk("fill_qty", rpt_qty, 24'h000064);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk("fill_popped", rpt_valid, 0);

    // Sequence gap: 5, 6, 9 from UNSYNC
    do_reset();
    rx_valid = 1'b1;
    rx_data  = mk(8'hA5, 8'h01, 16'h0005, 32'hA5, 32'h1, 24'h1);
    tick();
    rx_data  = mk(8'hA5, 8'h01, 16'h0006, 32'hA6, 32'h1, 24'h1);
    tick();
    chk("gap5", seq_gap, 0);
    chk("gap_synced", synced, 1);
    rx_data  = mk(8'hA5, 8'h01, 16'h0009, 32'hA9, 32'h1, 24'h1);
    tick();
    chk("gap6", seq_gap, 0);
    rx_valid = 1'b0;
    tick();
    chk("gap9", seq_gap, 1);
    tick();
    chk("gap_pulse_end", seq_gap, 0);
    rpt_ready = 1'b1;
    chk("gap_head5", rpt_order_id, 32'hA5);
    tick();
    chk("gap_head6", rpt_order_id, 32'hA6);
    tick();
    chk("gap_head9", rpt_order_id, 32'hA9);
    tick();
    chk("gap_drained", rpt_valid, 0);
    rpt_ready = 1'b0;
    send(mk(8'hA5, 8'h03, 16'h000A, 32'hAA, 32'h1, 24'h1));
    tick();
    chk("gap_next_A", seq_gap, 0);
    chk("reject_type", rpt_type, 8'h03);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;

    // Wrap: FFFF (gap vs expected 000B) then 0000 (no gap)
    send(mk(8'hA5, 8'h02, 16'hFFFF, 32'hF1, 32'h2, 24'h2));
    tick();
    chk("wrap_ffff_gap", seq_gap, 1);
    send(mk(8'hA5, 8'h02, 16'h0000, 32'hF2, 32'h2, 24'h2));
    tick();
    chk("wrap_0000_nogap", seq_gap, 0);
    rpt_ready = 1'b1;
    tick();
    tick();
    rpt_ready = 1'b0;
    chk("wrap_drained", rpt_valid, 0);

    // Bad frames leave expected_seq at 0001
    send(mk(8'h5A, 8'h02, 16'h0001, 32'hB1, 32'h3, 24'h3));
    tick();
    chk("bad_magic", bad_frame, 1);
    chk("bad_magic_norpt", rpt_valid, 0);
    tick();
    chk("bad_pulse_end", bad_frame, 0);
    send(mk(8'hA5, 8'h07, 16'h0001, 32'hB1, 32'h3, 24'h3));
    tick();
    chk("bad_type", bad_frame, 1);
    chk("bad_type_norpt", rpt_valid, 0);
    chk("bad_type_nogap", seq_gap, 0);
`ifdef EXEC_RX_CHECKSUM_EN
    f = mk(8'hA5, 8'h02, 16'h0001, 32'hB1, 32'h3, 24'h3);
    f[7:0] = f[7:0] ^ 8'h01;
    send(f);
    tick();
    chk("bad_csum", bad_frame, 1);
    chk("bad_csum_norpt", rpt_valid, 0);
`endif
    send(mk(8'hA5, 8'h02, 16'h0001, 32'hB1, 32'h3, 24'h3));
    tick();
    chk("after_bad_nogap", seq_gap, 0);
    chk("after_bad_good", bad_frame, 0);
    chk("after_bad_rpt", rpt_valid, 1);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;

    // Overflow: 6 frames into depth 4 with consumer stalled
    for (int i = 0; i < 6; i++) begin
      rx_data  = mk(8'hA5, 8'h02, 16'(2 + i), 32'hB0 + 32'(i), 32'h4, 24'h4);
      rx_valid = 1'b1;
      tick();
      if (i == 3) chk("ovf_head_mid", rpt_order_id, 32'hB0);
    end
    rx_valid = 1'b0;
    tick();
    chk("ovf_drop", drop_count, 2);
    chk("ovf_head", rpt_order_id, 32'hB0);
    chk("ovf_nogap", seq_gap, 0);
    rpt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", rpt_order_id, 32'hB0 + 32'(i));
      tick();
    end
    chk("ovf_only4", rpt_valid, 0);
    rpt_ready = 1'b0;

    // Full FIFO with simultaneous write and pop
    for (int i = 0; i < 4; i++) begin
      rx_data  = mk(8'hA5, 8'h02, 16'(8 + i), 32'hC0 + 32'(i), 32'h5, 24'h5);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    tick();
    send(mk(8'hA5, 8'h02, 16'h000C, 32'hC4, 32'h5, 24'h5));
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk("full_wp_nodrop", drop_count, 2);
    rpt_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("full_wp_drain", rpt_order_id, 32'hC0 + 32'(i));
      tick();
    end
    chk("full_wp_empty", rpt_valid, 0);
    rpt_ready = 1'b0;

    // Reset with 3 buffered reports
    for (int i = 0; i < 3; i++) begin
      rx_data  = mk(8'hA5, 8'h02, 16'(13 + i), 32'hD0 + 32'(i), 32'h6, 24'h6);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    tick();
    chk("mid_buffered", rpt_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", rpt_valid, 0);
    chk("mid_rst_synced", synced, 0);
    chk("mid_rst_oid", rpt_order_id, 0);
    chk("mid_rst_drop", drop_count, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("mid_lost", rpt_valid, 0);
    send(mk(8'hA5, 8'h01, 16'h0100, 32'hE0, 32'h7, 24'h7));
    tick();
    chk("relock_nogap", seq_gap, 0);
    chk("relock_synced", synced, 1);
    chk("relock_valid", rpt_valid, 1);
    chk("relock_oid", rpt_order_id, 32'hE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
